// File: rtl/dnn_acc_rd_dma.sv
// AXI read-DMA master for the DNN accelerator.
// Turns a (start address, beat count) command into 64-bit INCR bursts on the user_axi
// AR/R channels. A burst never crosses a 4 KB boundary and is issued only when the data
// FIFO has room for every beat of it. Returned data is buffered and presented as a
// valid/ready stream whose last beat is flagged.
// Ports:
//   user_clk, user_reset_n       clock, asynchronous active-low reset
//   cmd_*                        command request (valid/ready, byte address, beat count)
//   user_axi_ar*                 read address channel (master side)
//   user_axi_r*                  read data channel (master side)
//   out_*                        output data stream toward the compute datapath
//   busy, done, err              status: in progress, completion pulse, sticky bad rresp
module dnn_acc_rd_dma #(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter logic [5:0]  AXI_ID     = 6'd0
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_beats,
  output logic [31:0] user_axi_araddr,
  output logic [1:0]  user_axi_arburst,
  output logic [5:0]  user_axi_arid,
  output logic [3:0]  user_axi_arlen,
  output logic [2:0]  user_axi_arsize,
  output logic [3:0]  user_axi_arcache,
  output logic        user_axi_arvalid,
  input  logic        user_axi_arready,
  input  logic [63:0] user_axi_rdata,
  input  logic [5:0]  user_axi_rid,
  input  logic        user_axi_rlast,
  input  logic [1:0]  user_axi_rresp,
  input  logic        user_axi_rvalid,
  output logic        user_axi_rready,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;
  state_e state_q, state_d;

  logic [31:0]     addr_q, addr_d;
  logic [15:0]     remaining_q, remaining_d;
  logic [15:0]     beats_q, beats_d;
  logic [CntW-1:0] reserved_q, reserved_d;
  logic [4:0]      burst_q, burst_d;
  logic            arvalid_q, arvalid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [3:0]      arlen_q, arlen_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rready_en_q;

  logic [63:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [63:0]     out_data_q;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [15:0]     out_cnt_q, out_cnt_d;

  logic            push, pop, accept;
  logic [9:0]      to_4k;
  logic [4:0]      burst;
  logic            credit_ok;
  logic            unused_inputs;

  assign unused_inputs = ^{user_axi_rid, user_axi_rlast};

  assign accept          = (state_q == StIdle) && cmd_valid;
  // Held low for the first cycle out of reset, then low only when the FIFO is full.
  assign user_axi_rready = rready_en_q && (count_q != CntW'(FIFO_DEPTH));
  assign push            = user_axi_rvalid && user_axi_rready;
  assign pop             = (count_q != '0) && (!out_valid_q || out_ready);

  // Burst length: limited by MAX_BURST, the beats left and the distance to the 4 KB page end.
  always_comb begin
    to_4k = 10'd512 - {1'b0, addr_q[11:3]};
    burst = 5'(MAX_BURST);
    if (remaining_q < 16'(burst)) burst = 5'(remaining_q);
    if (to_4k < 10'(burst))       burst = 5'(to_4k);
    // The output register counts as occupied space so the total held never exceeds FIFO_DEPTH.
    credit_ok = (32'(count_q) + 32'(out_valid_q) + 32'(reserved_q) + 32'(burst))
                <= FIFO_DEPTH;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    burst_d     = burst_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    reserved_d  = reserved_q;

    if (arvalid_q && user_axi_arready) reserved_d = reserved_q + CntW'(burst_q);
    if (push && (reserved_d != '0))    reserved_d = reserved_d - CntW'(1);
    if (push && (user_axi_rresp != 2'b00)) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d      = {cmd_addr[31:3], 3'b000};
          remaining_d = cmd_beats;
          beats_d     = cmd_beats;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          state_d     = (cmd_beats == 16'd0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (arvalid_q) begin
          if (user_axi_arready) begin
            arvalid_d   = 1'b0;
            addr_d      = addr_q + (32'(burst_q) << 3);
            remaining_d = remaining_q - 16'(burst_q);
            if (remaining_d == 16'd0) state_d = StDrain;
          end
        end else if (credit_ok) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 4'(burst - 5'd1);
          burst_d   = burst;
        end
      end
      StDrain: begin
        if ((reserved_q == '0) && (count_q == '0) && !out_valid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d     = count_q + CntW'(push) - CntW'(pop);
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_cnt_d   = out_cnt_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (pop) begin
      out_valid_d = 1'b1;
      out_last_d  = (out_cnt_q == beats_q - 16'd1);
      out_cnt_d   = out_cnt_q + 16'd1;
    end
    if (accept) out_cnt_d = '0;
  end

  // Storage array has no reset; the pointers and count define its contents.
  always_ff @(posedge user_clk) begin
    if (push) mem_q[wptr_q] <= user_axi_rdata;
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      reserved_q  <= '0;
      burst_q     <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rready_en_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      reserved_q  <= reserved_d;
      burst_q     <= burst_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rready_en_q <= 1'b1;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_cnt_q   <= out_cnt_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop) begin
        rptr_q     <= rptr_q + PtrW'(1);
        out_data_q <= mem_q[rptr_q];
      end
    end
  end

  assign cmd_ready        = (state_q == StIdle);
  assign user_axi_araddr  = araddr_q;
  assign user_axi_arlen   = arlen_q;
  assign user_axi_arvalid = arvalid_q;
  assign user_axi_arburst = 2'b01;
  assign user_axi_arid    = AXI_ID;
  assign user_axi_arsize  = 3'b011;
  assign user_axi_arcache = 4'b0011;
  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule
